// File: rtl/mbus_fifo_port.sv
// -----------------------------------------------------------------------------
// mbus_fifo_port
//
// Memory-mapped dual-FIFO responder on the CPU mbus. CPU stores to TXDATA
// fill the TX FIFO, which an external consumer drains over a valid/ready
// stream. An external producer fills the RX FIFO over a valid/ready stream,
// and CPU loads from RXDATA read its head. Writing RXDATA pops RX.
//
// Register map (word at BASE_ADDR, offset = addr[1:0]):
//   0 TXDATA  W: push din           R: 0
//   1 RXDATA  W: pop (any value)    R: RX head, or 0 when empty
//   2 STATUS  R: [0] tx_empty [1] tx_full [2] rx_empty [3] rx_full
//                [4] tx_ovf (sticky) [5] rx_unf (sticky)
//                [15:8] tx_count [23:16] rx_count
//   3 CTRL    W: bit0 flush TX, bit1 flush RX, bit2 clear stickies,
//                bits[5:4] irq enables (stored only with the macro)
//             R: {26'b0, irq_en[1:0], 4'b0}
//
// Optional feature macro: MBUS_FIFO_IRQ_EN
//   Defined   -> irq port present, CTRL[5:4] stored as irq_en[1:0].
//   Undefined -> no irq port, CTRL[5:4] ignored and read as 0.
//
// Parameters:
//   WIDTH     bus data width (>= 24 so the STATUS fields fit)
//   ADDR_SIZE bus address width
//   BASE_ADDR address of register 0; bits [1:0] are ignored
//   DEPTH     entries per FIFO, power of 2, 2..128
//
// Ports:
//   clk       clock, all state changes on its rising edge
//   reset     asynchronous, active-low reset
//   addr      bus address (CPU mbus_aout)
//   din       bus write data (CPU mbus_dout)
//   wen       bus write strobe (CPU mbus_wen)
//   dout      registered read data (to CPU mbus_din via the system mux)
//   sel_out   registered; 1 when dout belongs to this block
//   tx_data   TX FIFO head
//   tx_valid  TX head valid (= !tx_empty)
//   tx_ready  consumer accepts the TX head
//   rx_data   producer word
//   rx_valid  producer word valid
//   rx_ready  RX FIFO can accept (= !rx_full)
//   irq       registered interrupt (only with MBUS_FIFO_IRQ_EN)
//
// Stream handshake (both directions): a word transfers on a rising clk edge
// where valid and ready are both 1. valid is not conditioned on ready, and
// the data is stable while valid is held high without a transfer.
// -----------------------------------------------------------------------------
module mbus_fifo_port #(
  parameter int                   WIDTH     = 32,
  parameter int                   ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = 32'hFF00,
  parameter int                   DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WIDTH-1:0]     din,
  input  logic                 wen,
  output logic [WIDTH-1:0]     dout,
  output logic                 sel_out,
  output logic [WIDTH-1:0]     tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [WIDTH-1:0]     rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready
`ifdef MBUS_FIFO_IRQ_EN
  ,
  output logic                 irq
`endif
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_INC = PW'(1);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_RXDATA = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       sel;
  logic [1:0] off;
  logic       bus_wr;
  logic       wr_txdata;
  logic       wr_rxpop;
  logic       wr_ctrl;
  logic       tx_flush;
  logic       rx_flush;
  logic       clr_sticky;

  assign sel        = (addr[ADDR_SIZE-1:2] == BASE_ADDR[ADDR_SIZE-1:2]);
  assign off        = addr[1:0];
  assign bus_wr     = wen & sel;
  assign wr_txdata  = bus_wr & (off == OFF_TXDATA);
  assign wr_rxpop   = bus_wr & (off == OFF_RXDATA);
  assign wr_ctrl    = bus_wr & (off == OFF_CTRL);
  assign tx_flush   = wr_ctrl & din[0];
  assign rx_flush   = wr_ctrl & din[1];
  assign clr_sticky = wr_ctrl & din[2];

  // ---------------------------------------------------------------------------
  // TX FIFO: CPU pushes, stream consumer pops
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [PW-1:0]    tx_wp;
  logic [PW-1:0]    tx_rp;
  logic [PW-1:0]    tx_count;
  logic             tx_empty;
  logic             tx_full;
  logic             tx_push;
  logic             tx_drop;
  logic             tx_pop;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_count = tx_wp - tx_rp;

  // Fullness is judged on the pointers before the edge, so a push into a
  // full FIFO is dropped even when the consumer pops in the same cycle.
  assign tx_push  = wr_txdata & ~tx_full;
  assign tx_drop  = wr_txdata & tx_full;
  assign tx_pop   = tx_valid & tx_ready;

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rp[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else if (tx_flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_INC;
      if (tx_pop)  tx_rp <= tx_rp + PTR_INC;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= din;
  end

  // ---------------------------------------------------------------------------
  // RX FIFO: stream producer pushes, CPU pops by writing RXDATA
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [PW-1:0]    rx_wp;
  logic [PW-1:0]    rx_rp;
  logic [PW-1:0]    rx_count;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_push;
  logic             rx_pop;
  logic             rx_unf_set;
  logic [WIDTH-1:0] rx_head;

  assign rx_empty   = (rx_wp == rx_rp);
  assign rx_full    = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_count   = rx_wp - rx_rp;

  assign rx_ready   = ~rx_full;
  assign rx_push    = rx_valid & rx_ready;
  assign rx_pop     = wr_rxpop & ~rx_empty;
  assign rx_unf_set = wr_rxpop & rx_empty;
  assign rx_head    = rx_mem[rx_rp[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else if (rx_flush) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PTR_INC;
      if (rx_pop)  rx_rp <= rx_rp + PTR_INC;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_data;
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags. Flushes leave them alone; only CTRL bit2 clears them.
  // ---------------------------------------------------------------------------
  logic tx_ovf;
  logic rx_unf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else if (clr_sticky) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_drop)    tx_ovf <= 1'b1;
      if (rx_unf_set) rx_unf <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt enables and interrupt (optional)
  // ---------------------------------------------------------------------------
  logic [1:0] irq_en_rd;

`ifdef MBUS_FIFO_IRQ_EN
  logic [1:0] irq_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 2'b00;
    end else if (wr_ctrl) begin
      irq_en <= din[5:4];
    end
  end

  // Level interrupt from pre-edge state: RX has data, TX drained, or any
  // sticky error. Cleared by consuming the cause or clearing the stickies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty) | tx_ovf | rx_unf;
    end
  end

  assign irq_en_rd = irq_en;
`else
  assign irq_en_rd = 2'b00;
`endif

  // ---------------------------------------------------------------------------
  // Read mux. Reads never change state because the CPU holds a load
  // address for several cycles.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] status_word;
  logic [WIDTH-1:0] ctrl_word;
  logic [WIDTH-1:0] rd_word;

  always_comb begin
    status_word        = '0;
    status_word[0]     = tx_empty;
    status_word[1]     = tx_full;
    status_word[2]     = rx_empty;
    status_word[3]     = rx_full;
    status_word[4]     = tx_ovf;
    status_word[5]     = rx_unf;
    status_word[15:8]  = 8'(tx_count);
    status_word[23:16] = 8'(rx_count);
  end

  always_comb begin
    ctrl_word      = '0;
    ctrl_word[5:4] = irq_en_rd;
  end

  always_comb begin
    rd_word = '0;
    case (off)
      OFF_TXDATA: rd_word = '0;
      OFF_RXDATA: rd_word = rx_empty ? '0 : rx_head;
      OFF_STATUS: rd_word = status_word;
      OFF_CTRL:   rd_word = ctrl_word;
      default:    rd_word = '0;
    endcase
  end

  // One-cycle read latency; values are those held before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout    <= '0;
      sel_out <= 1'b0;
    end else begin
      dout    <= sel ? rd_word : '0;
      sel_out <= sel;
    end
  end

endmodule

// File: doc/mbus_fifo_port.md
# mbus_fifo_port

Memory-mapped dual-FIFO responder on the CPU's mbus, the target side of the bus the CPU drives. It buffers words between the CPU and two valid/ready streams. The TX FIFO is filled by CPU stores and drained by an external consumer. The RX FIFO is filled by an external producer and read by CPU loads. It sits on the system bus beside program/data memory, and the system read mux selects its `dout` when `sel_out` is high.

## Interface
- `WIDTH`, 32, bus data width
- `ADDR_SIZE`, 32, bus address width
- `BASE_ADDR`, 32'hFF00, word address of register 0; bits [1:0] are ignored
- `DEPTH`, 16, entries per FIFO; power of 2, 2..128

- `clk`  in  1  the single clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `addr`  in  ADDR_SIZE  bus address (CPU `mbus_aout`)
- `din`  in  WIDTH  bus write data (CPU `mbus_dout`)
- `wen`  in  1  bus write strobe (CPU `mbus_wen`)
- `dout`  out  WIDTH  registered read data (to CPU `mbus_din` via mux)
- `sel_out`  out  1  registered; 1 when `dout` belongs to this block
- `tx_data`  out  WIDTH  TX FIFO head
- `tx_valid`  out  1  = !tx_empty
- `tx_ready`  in  1  consumer accepts the head
- `rx_data`  in  WIDTH  producer word
- `rx_valid`  in  1  producer word valid
- `rx_ready`  out  1  = !rx_full
- `irq`  out  1  only when `MBUS_FIFO_IRQ_EN` is defined

## Operation
- Decode: `sel` = (addr[ADDR_SIZE-1:2] == BASE_ADDR[ADDR_SIZE-1:2]). `off` = addr[1:0].
- Register map:
  - off 0 TXDATA: a write pushes `din`. Reads return 0.
  - off 1 RXDATA: reads return the RX head, or 0 if empty, with no side effect. A write of any value pops RX.
  - off 2 STATUS (read-only): [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_ovf (sticky), [5] rx_unf (sticky), [15:8] tx_count, [23:16] rx_count. All other bits are 0.
  - off 3 CTRL: writes act as follows. bit0=1 flushes TX, bit1=1 flushes RX, bit2=1 clears both sticky flags. bits[5:4] are the IRQ enables, stored only with the macro. Reads return {26'b0, irq_en[1:0], 4'b0}.
- Bus writes take effect when `wen & sel` at a clock edge. Reads have no side effects, because the CPU holds a load address for several cycles.
- Each FIFO is a circular buffer with read and write pointers of log2(DEPTH)+1 bits. Pointers wrap modulo 2·DEPTH.
  - empty when the pointers are equal.
  - full when the MSBs differ and the low bits are equal.
  - count = wp − rp.
- TX push is accepted iff !tx_full at the start of the cycle. A dropped push sets tx_ovf. TX pop occurs when `tx_valid & tx_ready`.
- RX push occurs when `rx_valid & rx_ready`. An RX pop when rx_empty is ignored and sets rx_unf.
- Simultaneous push and pop on one FIFO: both occur and the count is unchanged. On full TX, the push is dropped even though a pop happens in the same cycle.
- Flush resets both pointers of that FIFO to 0 and has priority over a same-cycle push or pop. Flush does not clear the stickies.

## Timing
- Read latency is 1 cycle. At each edge `dout` <= (sel ? reg[off] : 0) and `sel_out` <= sel. Register values are taken from before that edge.
- A write is visible in STATUS/RXDATA reads whose address phase starts on the cycle after the write edge.
- `tx_valid`/`tx_data`/`rx_ready` are combinational from registered pointers and storage. A pushed word appears on `tx_valid` 1 cycle after the push edge.
- Reset, asynchronous and immediate:
  - `dout`=0, `sel_out`=0.
  - Both FIFOs empty, so `tx_valid`=0 and `rx_ready`=1.
  - Stickies 0, irq_en 0, `irq`=0.
- Reset asserted mid-transfer discards all FIFO contents, with no partial word.

## Configuration
- `MBUS_FIFO_IRQ_EN` defined:
  - CTRL bits[5:4] are stored as irq_en[1:0].
  - `irq` is registered: irq <= (irq_en[0] & !rx_empty) | (irq_en[1] & tx_empty) | tx_ovf | rx_unf.
- Undefined:
  - `irq` port and enable storage are absent.
  - CTRL bits[5:4] are ignored and read 0.

## Test plan
- After reset, read off 2 → `dout`=32'h0000_0005 with `sel_out`=1 one cycle later. `tx_valid`=0, `rx_ready`=1.
- Push 3 words (0x11,0x22,0x33) to off 0 with `tx_ready`=0 → STATUS[15:8]=3. Set `tx_ready`=1 → `tx_data` 0x11,0x22,0x33 on consecutive cycles, then `tx_valid`=0.
- DEPTH+1 pushes with `tx_ready`=0 → tx_full=1, 17th word dropped, STATUS[4]=1. Write CTRL=4 → STATUS[4]=0, count stays 16.
- Drive RX 0xA5 then 0x5A, read off 1 → 0xA5. Write off 1, then read → 0x5A. Pop twice more → rx_unf=1, rx_count=0.
- Concurrent TX push and stream pop at count 5 for 10 cycles → count stays 5, data order preserved. Pointer wrap is exercised past 2·DEPTH.
- With the macro: CTRL=0x10, then an RX word arrives → `irq`=1 the next cycle. Pop it → `irq`=0 the cycle after.
